gpio_32_int_ctrl: RTL



---
 rtl/gpio_pkg.sv | 33 +++
 rtl/gpio_int_detect.sv | 43 ++++
 rtl/gpio_32_int_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO interrupt controller.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH = 32;
  localparam int unsigned IDX_W      = 5;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHoldoff
  } irq_state_e;

  typedef enum logic {
    IntLevel = 1'b0,
    IntEdge  = 1'b1
  } int_type_e;

  // Rising for edge pins, active-high for level pins.
  typedef enum logic {
    PolFallLow  = 1'b0,
    PolRiseHigh = 1'b1
  } int_pol_e;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [GPIO_WIDTH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = GPIO_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gpio_int_detect.sv
// Per-pin edge/level event detection for the GPIO bank; produces the raw hit vector.
module gpio_int_detect
  import gpio_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_WIDTH-1:0] pin,
  input  logic [GPIO_WIDTH-1:0] int_type,
  input  logic [GPIO_WIDTH-1:0] int_polarity,
  output logic [GPIO_WIDTH-1:0] hit
);

  logic [GPIO_WIDTH-1:0] prev_in;
  logic                  armed;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;

  // prev_in is zero out of reset, so edges stay gated until one real sample is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_in <= '0;
      armed   <= 1'b0;
    end else begin
      prev_in <= pin;
      armed   <= 1'b1;
    end
  end

  assign rise = pin & ~prev_in;
  assign fall = ~pin & prev_in;

  always_comb begin
    hit = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      if (int_type[i] == IntEdge) begin
        hit[i] = armed & ((int_polarity[i] == PolRiseHigh) ? rise[i] : fall[i]);
      end else begin
        hit[i] = (int_polarity[i] == PolRiseHigh) ? pin[i] : ~pin[i];
      end
    end
  end

endmodule

// File: rtl/gpio_32_int_ctrl.sv
// GPIO interrupt controller: sticky status, lowest-index encoder and registered IRQ.
// Define GPIO_IRQ_COALESCE_EN to enforce a HOLDOFF_CYCLES minimum low time on irq.
module gpio_32_int_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH          = GPIO_WIDTH,
  parameter int unsigned HOLDOFF_CYCLES = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] gpio_in_db,
  input  logic [WIDTH-1:0] int_mask,
  input  logic [WIDTH-1:0] int_type,
  input  logic [WIDTH-1:0] int_polarity,
  input  logic [WIDTH-1:0] int_clear,
  output logic [WIDTH-1:0] int_status,
  output logic             irq,
  output logic [IDX_W-1:0] irq_idx
);

  localparam bit CfgOk = (WIDTH == GPIO_WIDTH) && (HOLDOFF_CYCLES >= 1) &&
                         (HOLDOFF_CYCLES <= 65535);

  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic [WIDTH-1:0] pending;
  logic             pend;
  irq_state_e       state_q;
  irq_state_e       state_d;
  logic             irq_q;
  logic [IDX_W-1:0] idx_q;

`ifdef GPIO_IRQ_COALESCE_EN
  localparam logic [15:0] HoldoffLoad = 16'(HOLDOFF_CYCLES - 1);
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
`endif

  gpio_int_detect u_detect (
    .clk         (PCLK),
    .rst         (PRESET),
    .pin         (gpio_in_db),
    .int_type    (int_type),
    .int_polarity(int_polarity),
    .hit         (hit)
  );

  // Set wins over clear, so a live level source keeps its bit asserted.
  assign status_d = (status_q & ~int_clear) | hit;
  assign pending  = status_q & int_mask;
  assign pend     = |pending;

  always_comb begin
    state_d = state_q;
`ifdef GPIO_IRQ_COALESCE_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pend) state_d = StActive;
      end
      StActive: begin
        if (!pend) begin
`ifdef GPIO_IRQ_COALESCE_EN
          state_d = StHoldoff;
          cnt_d   = HoldoffLoad;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef GPIO_IRQ_COALESCE_EN
      StHoldoff: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 16'd1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      status_q <= '0;
      state_q  <= StIdle;
      irq_q    <= 1'b0;
      idx_q    <= '0;
`ifdef GPIO_IRQ_COALESCE_EN
      cnt_q    <= '0;
`endif
    end else begin
      status_q <= status_d;
      state_q  <= state_d;
      irq_q    <= (state_d == StActive);
      idx_q    <= lowest_idx(pending);
`ifdef GPIO_IRQ_COALESCE_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign int_status = status_q;
  assign irq        = irq_q;
  assign irq_idx    = idx_q;

  cfg_ok_a: assert property (@(posedge PCLK) CfgOk);

endmodule
